// File: rtl/widget_input_conditioner_if.sv
// Switch-side bundle between the raw player inputs and the PIA input pins.
// The master drives the raw switches, the E strobe and the bank select; the slave returns the PIA port values.
interface widget_input_conditioner_if;
    logic        en_e;
    logic [15:0] p1_sw_n;
    logic [15:0] p2_sw_n;
    logic        sel;
    logic [7:0]  pa_i;
    logic [7:0]  pb_i;
    logic        chg_o;

    modport master (output en_e, p1_sw_n, p2_sw_n, sel, input pa_i, pb_i, chg_o);
    modport slave  (input en_e, p1_sw_n, p2_sw_n, sel, output pa_i, pb_i, chg_o);
endinterface

// File: rtl/widget_input_conditioner.sv
// Synchronises and debounces two banks of active-low player switches, selects one bank for the
// PIA ports, and stretches a change strobe so the PIA's E-rate edge detector catches it.
module widget_debounce_bit #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CW = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw_n,
    output logic stable
);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          s;

    assign s = ~sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= 2'b11;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], raw_n};
            // Any agreeing cycle wipes the run, so only an unbroken disagreement commits.
            if (s == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                    stable <= s;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module widget_input_conditioner #(
    parameter int TICK_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CHG_HOLD_E     = 2
) (
    input logic                        clk,
    input logic                        rst,
    widget_input_conditioner_if.slave  bus
);
    localparam int NUM_LANES = 32;
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int HW = $clog2(CHG_HOLD_E + 1);

    logic [PW-1:0]          presc;
    logic                   tick;
    logic [NUM_LANES-1:0]   raw_n;
    logic [NUM_LANES-1:0]   stable;
    logic [15:0]            out_q;
    logic [15:0]            out_prev;
    logic                   sel_d1;
    logic                   sel_d2;
    logic                   chg_evt;
    logic                   chg_q;
    logic [HW-1:0]          hold;

    assign tick  = (presc == PW'(TICK_DIV - 1));
    assign raw_n = {bus.p2_sw_n, bus.p1_sw_n};

    always_ff @(posedge clk) begin
        if (rst) presc <= '0;
        else     presc <= tick ? '0 : presc + 1'b1;
    end

    // Both banks always debounce, so a bank switch exposes already-settled values.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        widget_debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .CW(CW)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .tick(tick),
            .raw_n(raw_n[i]),
            .stable(stable[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            out_prev <= '0;
            sel_d1   <= 1'b0;
            sel_d2   <= 1'b0;
        end else begin
            out_q    <= bus.sel ? stable[31:16] : stable[15:0];
            out_prev <= out_q;
            sel_d1   <= bus.sel;
            sel_d2   <= sel_d1;
        end
    end

    // A bank switch moves out_q one cycle after sel moves; masking both cycles keeps it silent.
    assign chg_evt = (out_q != out_prev) && (bus.sel == sel_d1) && (sel_d1 == sel_d2);

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q <= 1'b0;
            hold  <= '0;
        end else if (chg_evt) begin
            chg_q <= 1'b1;
            hold  <= HW'(CHG_HOLD_E);
        end else if (chg_q && bus.en_e) begin
            if (hold <= HW'(1)) begin
                hold  <= '0;
                chg_q <= 1'b0;
            end else begin
                hold <= hold - 1'b1;
            end
        end
    end

    assign bus.pa_i  = out_q[7:0];
    assign bus.pb_i  = out_q[15:8];
    assign bus.chg_o = chg_q;
endmodule

// File: tb/tb_widget_input_conditioner.sv
// Randomised and directed bench for widget_input_conditioner against a cycle-level reference model.
module tb_widget_input_conditioner;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    widget_input_conditioner_if bus();

    widget_input_conditioner #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DT), .CHG_HOLD_E(CH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
        n_chk++;
        if (got >= lo && got <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // E strobe: one clk in every eight
    int ecnt = 0;
    initial begin
        bus.en_e = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.en_e = (ecnt % 8 == 7);
            ecnt++;
        end
    end

    // Reference model: raw values seen two clocks late, a per-bit run length of disagreeing ticks,
    // tick phase taken from the cycle count since reset.
    bit [31:0] m_raw1, m_raw2, m_stable, m_s, m_nst;
    int        m_run[32];
    int        m_cyc;
    bit [15:0] m_out, m_prev, m_nout;
    bit        m_sel1, m_sel2, m_chg, m_tick, m_evt;
    int        m_hold;

    always @(posedge clk) begin
        if (rst) begin
            m_raw1 = '1; m_raw2 = '1; m_stable = '0; m_cyc = 0;
            for (int i = 0; i < 32; i++) m_run[i] = 0;
            m_out = '0; m_prev = '0; m_sel1 = 0; m_sel2 = 0; m_chg = 0; m_hold = 0;
        end else begin
            m_s    = ~m_raw2;
            m_tick = (m_cyc % TD) == TD - 1;
            m_nst  = m_stable;
            for (int i = 0; i < 32; i++) begin
                if (m_s[i] == m_stable[i]) m_run[i] = 0;
                else if (m_tick) begin
                    if (m_run[i] + 1 >= DT) begin
                        m_nst[i] = m_s[i];
                        m_run[i] = 0;
                    end else m_run[i] = m_run[i] + 1;
                end
            end
            m_nout = bus.sel ? m_stable[31:16] : m_stable[15:0];
            m_evt  = (m_out != m_prev) && (bus.sel == m_sel1) && (m_sel1 == m_sel2);
            if (m_evt) begin
                m_chg = 1; m_hold = CH;
            end else if (m_chg && bus.en_e) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_chg = 0;
            end
            m_raw2 = m_raw1; m_raw1 = {bus.p2_sw_n, bus.p1_sw_n};
            m_cyc++;
            m_prev = m_out; m_out = m_nout;
            m_sel2 = m_sel1; m_sel1 = bus.sel;
            m_stable = m_nst;
        end
    end

    int  rises = 0;
    bit  chg_last = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pa", {24'd0, bus.pa_i}, {24'd0, m_out[7:0]});
            chk("model_pb", {24'd0, bus.pb_i}, {24'd0, m_out[15:8]});
            chk("model_chg", {31'd0, bus.chg_o}, {31'd0, m_chg});
        end
        if (bus.chg_o && !chg_last) rises++;
        chg_last = bus.chg_o;
    end

    initial begin
        int n, r0, ec, t;
        bit bad, seen2, done;
        bus.p1_sw_n = '0; bus.p2_sw_n = '0; bus.sel = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // reset with everything pressed
        chk("rst_pa", {24'd0, bus.pa_i}, 32'h0);
        chk("rst_chg", {31'd0, bus.chg_o}, 32'h0);
        step(2);
        rst = 1'b0;
        r0 = rises;
        step(1);
        chk("post_rst_pab", {16'd0, bus.pb_i, bus.pa_i}, 32'h0);
        chk("post_rst_chg", {31'd0, bus.chg_o}, 32'h0);
        step(14);
        chk("rst_commit_pab", {16'd0, bus.pb_i, bus.pa_i}, 32'hFFFF);
        chk("model_pin_commit", {16'd0, m_out}, 32'hFFFF);
        step(40);
        chk("rst_commit_one_chg", rises - r0, 1);

        // clean press
        bus.p1_sw_n = '1; bus.p2_sw_n = '1;
        step(60);
        chk("released_pab", {16'd0, bus.pb_i, bus.pa_i}, 32'h0);
        bus.p1_sw_n[0] = 1'b0;
        n = 0;
        while (!bus.pa_i[0] && n < 30) begin step(1); n++; end
        chk_rng("press_latency", n, 12, 16);
        step(1);
        chk("press_chg_high", {31'd0, bus.chg_o}, 32'h1);
        ec = 0; t = 0;
        while (bus.chg_o && t < 40) begin
            @(negedge clk);
            if (bus.en_e) ec++;
            @(posedge clk); #1;
            t++;
        end
        chk("press_chg_fell", {31'd0, bus.chg_o}, 32'h0);
        chk("press_chg_en_count", ec, 2);
        chk("press_pb_zero", {24'd0, bus.pb_i}, 32'h0);
        bus.p1_sw_n[0] = 1'b1;
        step(60);

        // bounce rejection
        r0 = rises; bad = 0;
        repeat (5) begin
            bus.p1_sw_n[3] = 1'b0;
            repeat (3) begin step(1); if (bus.pa_i != 0 || bus.chg_o) bad = 1; end
            bus.p1_sw_n[3] = 1'b1;
            repeat (3) begin step(1); if (bus.pa_i != 0 || bus.chg_o) bad = 1; end
        end
        repeat (20) begin step(1); if (bus.pa_i != 0 || bus.chg_o) bad = 1; end
        chk("bounce_quiet", {31'd0, bad}, 32'h0);
        chk("bounce_no_chg", rises - r0, 0);

        // silent bank switch
        r0 = rises; bad = 0;
        bus.p2_sw_n = 16'h7FFE;
        repeat (40) begin step(1); if (bus.pa_i != 0 || bus.pb_i != 0) bad = 1; end
        chk("bank_hidden", {31'd0, bad}, 32'h0);
        chk("bank_hidden_no_chg", rises - r0, 0);
        bus.sel = 1'b1;
        step(1);
        chk("bank_pa", {24'd0, bus.pa_i}, 32'h01);
        chk("bank_pb", {24'd0, bus.pb_i}, 32'h80);
        chk("bank_chg", {31'd0, bus.chg_o}, 32'h0);
        chk("model_pin_bank", {16'd0, m_out}, 32'h8001);
        step(20);
        chk("bank_switch_no_chg", rises - r0, 0);
        bus.sel = 1'b0; bus.p2_sw_n = '1;
        step(60);

        // two commits two ticks apart merge into one reloaded pulse
        r0 = rises; ec = 0; seen2 = 0; done = 0;
        bus.p1_sw_n[1] = 1'b0;
        step(8);
        bus.p1_sw_n[2] = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (seen2 && bus.chg_o && bus.en_e) ec++;
            if (bus.pa_i == 8'h06) seen2 = 1;
            if (seen2 && !bus.chg_o) done = 1;
        end
        @(posedge clk); #1;
        chk("merge_done", {31'd0, done}, 32'h1);
        chk("merge_single_pulse", rises - r0, 1);
        chk("merge_en_after_reload", ec, 2);
        bus.p1_sw_n = '1;
        step(60);

        // reset mid-debounce
        bus.p1_sw_n[5] = 1'b0;
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_pa", {24'd0, bus.pa_i}, 32'h0);
        n = 0;
        while (!bus.pa_i[5] && n < 30) begin step(1); n++; end
        chk_rng("mid_rst_latency", n, 12, 16);
        bus.p1_sw_n = '1;
        step(60);

        // random traffic, model compared every cycle
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(5) == 0) begin
                int b;
                b = $urandom_range(31);
                if (b < 16) bus.p1_sw_n[b] = ~bus.p1_sw_n[b];
                else        bus.p2_sw_n[b-16] = ~bus.p2_sw_n[b-16];
            end
            if ($urandom_range(63) == 0) bus.sel = ~bus.sel;
            rst = ($urandom_range(699) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
